// File: rtl/spk_bin_pkg.sv
// Shared types and sizing for the spike bin loader.
// Channel index width and RAM address width are fixed by the feature RAM interface.
package spk_bin_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int CH_NUM_DEF = 96;
  localparam int CH_W       = 7;
  localparam int ADDR_W     = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2,
    KICK   = 2'd3
  } state_t;

endpackage

// File: rtl/spk_bin_bank.sv
// One bank of per-channel spike counters: increment port plus read-and-clear port.
// Optional macro SPK_BIN_SAT_EN makes counts saturate instead of wrapping.
module spk_bin_bank
  import spk_bin_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CH_NUM = CH_NUM_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc_en,
  input  logic [CH_W-1:0]  i_inc_idx,
  input  logic             i_clr_en,
  input  logic [CH_W-1:0]  i_clr_idx,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_cnt [CH_NUM];
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_inc;

  assign w_cur     = r_cnt[i_inc_idx];
  assign o_rd_data = r_cnt[i_clr_idx];

`ifdef SPK_BIN_SAT_EN
  assign w_inc = (&w_cur) ? w_cur : w_cur + 1'b1;
`else
  assign w_inc = w_cur + 1'b1;
`endif

  // A bank is either counting or being read out, never both, so the two writes cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) r_cnt[i] <= '0;
    end else begin
      if (i_inc_en) r_cnt[i_inc_idx] <= w_inc;
      if (i_clr_en) r_cnt[i_clr_idx] <= '0;
    end
  end

endmodule

// File: rtl/spike_bin_loader.sv
// Bins spike events per channel into ping-pong banks and streams each closed bin to the
// Wiener filter feature RAM, then kicks the filter. Build option: SPK_BIN_SAT_EN.
//
// state  | meaning
// IDLE   | waiting for the bin counter terminal count
// STREAM | writing readout-bank count r_idx to the RAM, clearing it
// GAP    | one idle cycle after the last write
// KICK   | start pulse to the filter
module spike_bin_loader
  import spk_bin_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CH_NUM  = CH_NUM_DEF,
  parameter int BIN_LEN = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spike_v,
  input  logic [CH_W-1:0]   spike_ch,
  input  logic              filt_done,
  output logic [ADDR_W-1:0] wr_data_addr,
  output logic              ram_wr_data_en,
  output logic [WIDTH-1:0]  ram_data_wr_in,
  output logic              start,
  output logic              spike_drop,
  output logic              overrun
);

  localparam int               BIN_CW   = $clog2(BIN_LEN);
  localparam logic [BIN_CW-1:0] BIN_TC  = BIN_CW'(BIN_LEN - 1);
  localparam logic [CH_W:0]     CH_LIM  = (CH_W + 1)'(CH_NUM);
  localparam logic [CH_W-1:0]   IDX_LAST = CH_W'(CH_NUM - 1);

  logic [BIN_CW-1:0] r_bin_cnt;
  logic              r_bank_sel;
  logic              r_drop;
  logic              r_busy;
  logic              r_overrun;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_idx;
  logic              w_bin_tc;
  logic              w_spike_ok;
  logic              w_spike_bad;
  logic              w_stream;
  logic              w_kick;
  logic [WIDTH-1:0]  w_rd0;
  logic [WIDTH-1:0]  w_rd1;
  logic [WIDTH-1:0]  w_rd;

  assign w_bin_tc    = (r_bin_cnt == BIN_TC);
  assign w_spike_ok  = spike_v && ({1'b0, spike_ch} <  CH_LIM);
  assign w_spike_bad = spike_v && ({1'b0, spike_ch} >= CH_LIM);

  // Bank select flips on the terminal-count edge, so a spike in cycle T still lands in the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_cnt  <= '0;
      r_bank_sel <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_bin_cnt <= w_bin_tc ? '0 : r_bin_cnt + 1'b1;
      if (w_bin_tc) r_bank_sel <= ~r_bank_sel;
      r_drop <= w_spike_bad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= (w_stream && (r_idx != IDX_LAST)) ? r_idx + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stream    = 1'b0;
    w_kick      = 1'b0;
    case (r_state)
      IDLE:   if (w_bin_tc) w_state_nxt = STREAM;
      STREAM: begin
        w_stream = 1'b1;
        if (r_idx == IDX_LAST) w_state_nxt = GAP;
      end
      GAP:    w_state_nxt = KICK;
      KICK:   begin
        w_kick      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A coincident filt_done acknowledges the previous run, so it is not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_kick) begin
      r_busy <= 1'b1;
      if (r_busy && !filt_done) r_overrun <= 1'b1;
    end else if (filt_done) begin
      r_busy <= 1'b0;
    end
  end

  spk_bin_bank #(.WIDTH(WIDTH), .CH_NUM(CH_NUM)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .i_inc_en  (w_spike_ok && !r_bank_sel),
    .i_inc_idx (spike_ch),
    .i_clr_en  (w_stream && r_bank_sel),
    .i_clr_idx (r_idx),
    .o_rd_data (w_rd0)
  );

  spk_bin_bank #(.WIDTH(WIDTH), .CH_NUM(CH_NUM)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .i_inc_en  (w_spike_ok && r_bank_sel),
    .i_inc_idx (spike_ch),
    .i_clr_en  (w_stream && !r_bank_sel),
    .i_clr_idx (r_idx),
    .o_rd_data (w_rd1)
  );

  assign w_rd           = r_bank_sel ? w_rd0 : w_rd1;
  assign ram_wr_data_en = w_stream;
  assign wr_data_addr   = w_stream ? ADDR_W'(r_idx) : '0;
  assign ram_data_wr_in = w_stream ? w_rd : '0;
  assign start          = w_kick;
  assign spike_drop     = r_drop;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_spike_bin_loader.sv
// Self-checking bench for spike_bin_loader: directed bins plus random spikes vs a per-bin count model.
// Honours SPK_BIN_SAT_EN in the reference model the same way the design build does.
module tb_spike_bin_loader;

  localparam int WIDTH   = 6;
  localparam int CH_NUM  = 96;
  localparam int BIN_LEN = 128;
  localparam int CNT_MAX = (1 << WIDTH) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spike_v = 1'b0;
  logic [6:0]  spike_ch = '0;
  logic        filt_done = 1'b0;
  logic [16:0] wr_data_addr;
  logic        ram_wr_data_en;
  logic [WIDTH-1:0] ram_data_wr_in;
  logic        start;
  logic        spike_drop;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seg = 0;
  int acc  [CH_NUM];
  int snap [CH_NUM];
  bit prev_bad, m_busy, m_ovr;

  spike_bin_loader #(.WIDTH(WIDTH), .CH_NUM(CH_NUM), .BIN_LEN(BIN_LEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .spike_v        (spike_v),
    .spike_ch       (spike_ch),
    .filt_done      (filt_done),
    .wr_data_addr   (wr_data_addr),
    .ram_wr_data_en (ram_wr_data_en),
    .ram_data_wr_in (ram_data_wr_in),
    .start          (start),
    .spike_drop     (spike_drop),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  function automatic int exp_count(int n);
`ifdef SPK_BIN_SAT_EN
    return (n > CNT_MAX) ? CNT_MAX : n;
`else
    return n % (CNT_MAX + 1);
`endif
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s seg %0d cyc %0d got %0d exp %0d", tag, seg, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"},    int'(ram_wr_data_en), 0);
    chk({tag, "_addr"},  int'(wr_data_addr),   0);
    chk({tag, "_data"},  int'(ram_data_wr_in), 0);
    chk({tag, "_start"}, int'(start),          0);
    chk({tag, "_drop"},  int'(spike_drop),     0);
    chk({tag, "_ovr"},   int'(overrun),        0);
  endtask

  task automatic model_reset();
    cyc = 0;
    foreach (acc[i]) acc[i] = 0;
    foreach (snap[i]) snap[i] = 0;
    prev_bad = 0;
    m_busy   = 0;
    m_ovr    = 0;
  endtask

  function automatic logic [6:0] rand_ch(input bit avoid10, input bit avoid0);
    logic [6:0] c;
    c = 7'($urandom_range(127));
    if (avoid10 && c == 7'd10) c = 7'd11;
    if (avoid0 && c == 7'd0) c = 7'd1;
    return c;
  endfunction

  task automatic drive(input int bin, input int p);
    spike_v   = 1'b0;
    spike_ch  = '0;
    filt_done = 1'b0;
    if (seg == 0) begin
      case (bin)
        0: begin
          if (p >= 10 && p <= 14) begin spike_v = 1'b1; spike_ch = 7'd3; end
          if (p == 20) begin spike_v = 1'b1; spike_ch = 7'd95; end
        end
        1: begin
          if (p == 30) begin spike_v = 1'b1; spike_ch = 7'd100; end
          if (p >= 40 && p <= 120 && $urandom_range(2) == 0) begin
            spike_v = 1'b1; spike_ch = rand_ch(1'b1, 1'b0);
          end
          if (p == BIN_LEN - 1) begin spike_v = 1'b1; spike_ch = 7'd10; end
          if (p == CH_NUM + 5) filt_done = 1'b1;
        end
        2: begin
          if (p == 0) begin spike_v = 1'b1; spike_ch = 7'd10; end
          if (p >= 10 && p <= 120 && $urandom_range(2) == 0) begin
            spike_v = 1'b1; spike_ch = rand_ch(1'b1, 1'b0);
          end
        end
        3: begin
          if (p < 100) begin spike_v = 1'b1; spike_ch = 7'd0; end
          if (p >= 100 && p <= 125 && $urandom_range(1) == 0) begin
            spike_v = 1'b1; spike_ch = rand_ch(1'b0, 1'b1);
          end
          if (p == CH_NUM + 1) filt_done = 1'b1;
        end
        4: begin
          if (p <= 120 && $urandom_range(1) == 0) begin
            spike_v = 1'b1; spike_ch = rand_ch(1'b0, 1'b0);
          end
        end
        default: ;
      endcase
    end else begin
      if (bin == 1 && p >= 20 && p <= 110 && $urandom_range(1) == 0) begin
        spike_v = 1'b1; spike_ch = rand_ch(1'b0, 1'b0);
      end
      if (bin >= 1 && p == CH_NUM + 3) filt_done = 1'b1;
    end
  endtask

  task automatic check_cycle(input int bin, input int p, output bit kick);
    bit strm;
    if (bin >= 1 && p == 0) begin
      snap = acc;
      foreach (acc[i]) acc[i] = 0;
    end
    strm = (bin >= 1) && (p < CH_NUM);
    kick = (bin >= 1) && (p == CH_NUM + 1);
    chk("wr_en", int'(ram_wr_data_en), int'(strm));
    if (strm) begin
      chk("addr", int'(wr_data_addr),   p);
      chk("data", int'(ram_data_wr_in), exp_count(snap[p]));
    end else begin
      chk("addr_idle", int'(wr_data_addr),   0);
      chk("data_idle", int'(ram_data_wr_in), 0);
    end
    chk("start",   int'(start),      int'(kick));
    chk("drop",    int'(spike_drop), int'(prev_bad));
    chk("overrun", int'(overrun),    int'(m_ovr));
  endtask

  task automatic advance(input bit kick);
    prev_bad = spike_v && (int'(spike_ch) >= CH_NUM);
    if (spike_v && int'(spike_ch) < CH_NUM) acc[int'(spike_ch)]++;
    if (kick) begin
      if (m_busy && !filt_done) m_ovr = 1;
      m_busy = 1;
    end else if (filt_done) begin
      m_busy = 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int  bin, p;
    bit  kick;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst_init");
    rst = 1'b0;
    forever begin
      bin = cyc / BIN_LEN;
      p   = cyc % BIN_LEN;
      if (seg == 1 && bin == 2 && p == CH_NUM + 10) break;
      drive(bin, p);
      check_cycle(bin, p, kick);
      if (seg == 0 && bin == 5 && p == 40) begin
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          check_zero("rst_hold");
        end
        rst = 1'b0;
        model_reset();
        seg = 1;
        continue;
      end
      advance(kick);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_bin_loader.md
SPIKE_BIN_LOADER -- requirements
Module: spike_bin_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning count and output data width.
REQ-002 SHALL have parameter CH_NUM, default 96, meaning number of channels, equal to the Wienerfilter COL_NUM.
REQ-003 SHALL have parameter BIN_LEN, default 4096, meaning bin length in clk cycles; legal only if BIN_LEN >= CH_NUM+4.
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port spike_v, input, 1, spike event valid.
REQ-007 SHALL have port spike_ch, input, 7, channel index of the spike event.
REQ-008 SHALL have port filt_done, input, 1, Wienerfilter finish_cal_o pulse.
REQ-009 SHALL have port wr_data_addr, output, 17, feature RAM write address, upper 10 bits zero.
REQ-010 SHALL have port ram_wr_data_en, output, 1, feature RAM write enable.
REQ-011 SHALL have port ram_data_wr_in, output, WIDTH, feature count written to the RAM.
REQ-012 SHALL have port start, output, 1, one-cycle pulse that launches the Wiener calculation.
REQ-013 SHALL have port spike_drop, output, 1, one-cycle pulse when spike_ch >= CH_NUM.
REQ-014 SHALL have port overrun, output, 1, sticky flag set when start issues while the filter is still busy.

Function
REQ-015 SHALL count spikes per channel in two ping-pong banks of CH_NUM x WIDTH counters: the active bank counts, the readout bank streams out.
REQ-016 SHALL increment the active-bank count for spike_ch in the same cycle when spike_v=1 and spike_ch<CH_NUM; the new value is visible the next cycle.
REQ-017 SHALL ignore a spike with spike_ch>=CH_NUM, leave all counts unchanged, and pulse spike_drop in the next cycle.
REQ-018 SHALL run a free-running bin counter 0..BIN_LEN-1; at terminal count (cycle T) it swaps banks at the T->T+1 edge.
REQ-019 SHALL count a spike arriving in cycle T into the old bank; a spike in cycle T+1 counts into the new bank.
REQ-020 SHALL use FSM states IDLE, STREAM, GAP and KICK; IDLE goes to STREAM on the swap.
REQ-021 In STREAM, SHALL assert ram_wr_data_en for exactly CH_NUM consecutive cycles T+1..T+CH_NUM, with address k=0..CH_NUM-1 and data equal to readout-bank count k.
REQ-022 SHALL clear each readout-bank entry to 0 in the cycle it is streamed.
REQ-023 After the last write, SHALL spend one cycle in GAP, then KICK asserts start for one cycle at T+CH_NUM+2, then return to IDLE.
REQ-024 SHALL track a busy flag that is set by start and cleared by filt_done; if start issues while busy=1, overrun SHALL set and hold until reset.
REQ-025 If filt_done and start occur in the same cycle, busy SHALL remain 1 and overrun SHALL NOT set.
REQ-026 Without SPK_BIN_SAT_EN, a count at 2^WIDTH-1 SHALL wrap to 0 on increment.

Reset
REQ-027 While rst=1, SHALL hold all counts, the bin counter and the bank select at 0, the FSM in IDLE, and busy and overrun at 0.
REQ-028 While rst=1, SHALL drive wr_data_addr, ram_wr_data_en, ram_data_wr_in, start and spike_drop to 0.
REQ-029 On reset mid-stream, SHALL abort the stream with no start pulse; the first bin after release closes at cycle BIN_LEN-1.

Configuration
REQ-030 With macro SPK_BIN_SAT_EN defined, counts SHALL saturate at 2^WIDTH-1; without it, counts SHALL wrap (REQ-026).

Structure
REQ-031 SHALL place WIDTH and CH_NUM defaults, CH_W=7, ADDR_W=17 and the FSM state typedef in the shared package spk_bin_pkg.
REQ-032 SHALL implement each counter bank as the sub-module spk_bin_bank (increment port plus read-and-clear port), instantiated twice.

Verification
REQ-033 With BIN_LEN=128, 5 spikes on ch 3 and 1 spike on ch 95 in bin 0 -> writes at cycles 128..223 carry addr 3=5, addr 95=1, all others 0; start at cycle 225.
REQ-034 A spike on ch 10 in cycle T and another in cycle T+1 -> the ch 10 count is 1 in bin 0's stream and 1 in bin 1's stream.
REQ-035 spike_ch=100 -> spike_drop pulses once and all streamed counts are unchanged.
REQ-036 70000 spikes on ch 0 in one bin -> streamed count is 4464 without SPK_BIN_SAT_EN and 65535 with it.
REQ-037 filt_done withheld after the first start -> overrun=1 at the second start; filt_done coincident with the second start -> overrun stays 0.
REQ-038 rst asserted at stream address 40 -> all outputs 0 immediately, no start pulse, and the next bin streams all zeros.
